core_launcher: RTL and testbench

Per-slave-core run controller sitting directly downstream of the core start/state controller. It turns a one-cycle start request and start address into a clean reset/PC-load/run sequence for one slave j1 core. It watches that core for a halt and returns a one-cycle end pulse upstream. One instance exists per slave core: cpu1 and cpu2.

---
 rtl/core_launcher_pkg.sv | 17 +
 rtl/core_launcher_watchdog.sv | 36 +++
 rtl/core_launcher.sv | 142 ++++++++++++++
 tb/tb_core_launcher.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_launcher_pkg.sv
// core_launcher_pkg
//   Shared definitions for the slave-core launcher: the launch FSM state
//   encoding and its width, and the default program-counter width.
//   Imported by core_launcher (top).
package core_launcher_pkg;

    localparam int PC_WIDTH           = 13;
    localparam int LAUNCH_STATE_WIDTH = 2;

    typedef enum logic [LAUNCH_STATE_WIDTH-1:0] {
        LS_IDLE   = 2'd0,
        LS_BOOT   = 2'd1,
        LS_RUN    = 2'd2,
        LS_FINISH = 2'd3
    } launch_state_t;

endpackage

// File: rtl/core_launcher_watchdog.sv
// core_watchdog
//   Run-time watchdog for one slave core. The counter sits at zero whenever
//   the core is not running and advances once per RUN cycle, so each run
//   starts counting from zero. 'expired' is high during the RUN cycle whose
//   count equals WDT_LIMIT-1, i.e. the WDT_LIMIT-th RUN cycle.
//   Only instantiated when CORE_WATCHDOG_EN is defined.
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous, active-high reset
//   run      in   launcher FSM is in RUN
//   expired  out  run budget used up this cycle
module core_watchdog #(
    parameter int               WDT_W     = 16,
    parameter logic [WDT_W-1:0] WDT_LIMIT = {WDT_W{1'b1}}
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic expired
);

    logic [WDT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (!run) begin
            count <= '0;
        end else begin
            count <= count + WDT_W'(1);
        end
    end

    assign expired = run && (count == (WDT_LIMIT - WDT_W'(1)));

endmodule

// File: rtl/core_launcher.sv
// core_launcher
//   Per-slave-core run controller. Converts a one-cycle start request into
//   a reset / PC-load / run sequence for one slave j1 core, watches for the
//   core's halt and returns a one-cycle end pulse upstream.
//   Optional feature: define CORE_WATCHDOG_EN to add a run-length watchdog
//   that forces FINISH and sets the sticky 'timeout' flag.
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous, active-high reset
//   start         in   one-cycle launch request
//   start_adr     in   launch address, captured only on an accepted start
//   core_halt     in   slave core has halted (level, looked at in RUN only)
//   core_rst      out  hold slave core in reset
//   core_en       out  slave core clock enable
//   core_pc_load  out  force slave PC to core_pc_init
//   core_pc_init  out  latched launch address
//   end_pulse     out  one-cycle completion pulse (the FINISH cycle)
//   busy          out  FSM not in IDLE
//   start_rej     out  one-cycle pulse in the cycle after a start that was
//                      sampled while busy (registered, no input->output path)
//   timeout       out  sticky: last run was ended by the watchdog
//   state         out  current FSM state, for observation
// Handshake: start is a single-cycle request with no ready; it is accepted
// only when sampled in IDLE, otherwise dropped and flagged on start_rej.
module core_launcher
    import core_launcher_pkg::*;
#(
    parameter int               PC_W        = PC_WIDTH,
    parameter int               BOOT_CYCLES = 2,
    parameter int               WDT_W       = 16,
    parameter logic [WDT_W-1:0] WDT_LIMIT   = {WDT_W{1'b1}}
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [PC_W-1:0]               start_adr,
    input  logic                          core_halt,
    output logic                          core_rst,
    output logic                          core_en,
    output logic                          core_pc_load,
    output logic [PC_W-1:0]               core_pc_init,
    output logic                          end_pulse,
    output logic                          busy,
    output logic                          start_rej,
    output logic                          timeout,
    output logic [LAUNCH_STATE_WIDTH-1:0] state
);

    localparam int              BOOT_W    = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [BOOT_W-1:0] BOOT_LOAD = BOOT_W'(BOOT_CYCLES - 1);

    launch_state_t     state_q;
    launch_state_t     state_next;
    logic [BOOT_W-1:0] boot_cnt;
    logic              accept;
    logic              wdt_expired;

    assign accept = start && (state_q == LS_IDLE);
    assign state  = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= LS_IDLE;
            boot_cnt     <= '0;
            core_pc_init <= '0;
            start_rej    <= 1'b0;
        end else begin
            state_q   <= state_next;
            start_rej <= start && (state_q != LS_IDLE);
            if (accept) begin
                core_pc_init <= start_adr;
                boot_cnt     <= BOOT_LOAD;
            end else if ((state_q == LS_BOOT) && (boot_cnt != '0)) begin
                boot_cnt <= boot_cnt - BOOT_W'(1);
            end
        end
    end

    // Next state and state-decoded outputs. Outputs depend on state_q only.
    always_comb begin
        state_next   = state_q;
        core_rst     = 1'b1;
        core_en      = 1'b0;
        core_pc_load = 1'b0;
        end_pulse    = 1'b0;
        busy         = 1'b1;
        unique case (state_q)
            LS_IDLE: begin
                busy = 1'b0;
                if (start) state_next = LS_BOOT;
            end
            LS_BOOT: begin
                core_pc_load = 1'b1;
                if (boot_cnt == '0) state_next = LS_RUN;
            end
            LS_RUN: begin
                core_rst = 1'b0;
                core_en  = 1'b1;
                if (core_halt || wdt_expired) state_next = LS_FINISH;
            end
            LS_FINISH: begin
                end_pulse  = 1'b1;
                state_next = LS_IDLE;
            end
            default: state_next = LS_IDLE;
        endcase
    end

`ifdef CORE_WATCHDOG_EN
    logic timeout_q;

    core_watchdog #(
        .WDT_W     (WDT_W),
        .WDT_LIMIT (WDT_LIMIT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .run     (state_q == LS_RUN),
        .expired (wdt_expired)
    );

    // Halt and expiry in the same cycle count as a normal halt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else if (accept) begin
            timeout_q <= 1'b0;
        end else if (wdt_expired && !core_halt) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_wdt;

    assign wdt_expired = 1'b0;
    assign timeout     = 1'b0;
    assign unused_wdt  = ^WDT_LIMIT;
`endif

endmodule

// File: tb/tb_core_launcher.sv
// tb_core_launcher
//   Self-checking bench for core_launcher. Driver tasks issue launches and
//   push the expected end events and reject pulses into queues; a monitor
//   on the falling edge pops and compares whenever end_pulse or start_rej
//   is seen. Build with CORE_WATCHDOG_EN defined to exercise the watchdog
//   (limit 8 here).
module tb_core_launcher;
    import core_launcher_pkg::*;

    localparam int PC_W = 13;
    localparam int B    = 2;
    localparam int W    = 32 + PC_W + 1;
`ifdef CORE_WATCHDOG_EN
    localparam int WDT_L = 8;
`else
    localparam int WDT_L = 1000000;
`endif

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic                          start = 1'b0;
    logic [PC_W-1:0]               start_adr = '0;
    logic                          core_halt = 1'b0;
    logic                          core_rst;
    logic                          core_en;
    logic                          core_pc_load;
    logic [PC_W-1:0]               core_pc_init;
    logic                          end_pulse;
    logic                          busy;
    logic                          start_rej;
    logic                          timeout;
    logic [LAUNCH_STATE_WIDTH-1:0] state;

    int             cyc = 0;
    int             n_checks = 0;
    int             n_fail = 0;
    logic [W-1:0]   exp_q[$];
    int             rej_q[$];
    logic [W-1:0]   mon_exp;
    logic [W-1:0]   mon_act;
    int             mon_rej;

    core_launcher #(
        .PC_W        (PC_W),
        .BOOT_CYCLES (B),
        .WDT_W       (16),
        .WDT_LIMIT   (16'd8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .start_adr    (start_adr),
        .core_halt    (core_halt),
        .core_rst     (core_rst),
        .core_en      (core_en),
        .core_pc_load (core_pc_load),
        .core_pc_init (core_pc_init),
        .end_pulse    (end_pulse),
        .busy         (busy),
        .start_rej    (start_rej),
        .timeout      (timeout),
        .state        (state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL sim_time_limit: bench did not finish, cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (end_pulse) begin
                mon_act = {32'(cyc), core_pc_init, timeout};
                if (exp_q.size() == 0) begin
                    chk("end_unexpected", 64'(mon_act), 64'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("end_event{cycle,pc,timeout}", 64'(mon_act), 64'(mon_exp));
                end
            end
            if (start_rej) begin
                if (rej_q.size() == 0) begin
                    chk("rej_unexpected", 64'(cyc), 64'd0);
                end else begin
                    mon_rej = rej_q.pop_front();
                    chk("rej_cycle", 64'(cyc), 64'(mon_rej));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a falling edge with the DUT idle. Core halts in RUN cycle k
    // (1-based) unless the watchdog limit comes first. rej_k: RUN cycle in
    // which a spurious start is driven (0 = none).
    task automatic launch(input logic [PC_W-1:0] adr, input int k, input int rej_k,
                          input bit boot_rej, input bit fin_rej);
        int t;
        int fin;
        int eff;
        bit to;
        eff = (k < WDT_L) ? k : WDT_L;
        to  = (k > WDT_L);
        start = 1'b1;
        start_adr = adr;
        t = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        start_adr = PC_W'($urandom);
        chk("timeout_cleared", 64'(timeout), 64'd0);
        for (int b = 0; b < B; b++) begin
            chk("boot_pc_load", 64'(core_pc_load), 64'd1);
            chk("boot_pc_init", 64'(core_pc_init), 64'(adr));
            chk("boot_en", 64'(core_en), 64'd0);
            chk("boot_busy", 64'(busy), 64'd1);
            if (b == 0 && boot_rej) begin
                start = 1'b1;
                rej_q.push_back(cyc + 1);
            end
            @(negedge clk);
            start = 1'b0;
            start_adr = PC_W'($urandom);
        end
        chk("run_start_cycle", 64'(cyc), 64'(t + B));
        chk("run_en", 64'(core_en), 64'd1);
        chk("run_rst", 64'(core_rst), 64'd0);
        chk("run_pc_load", 64'(core_pc_load), 64'd0);
        fin = t + B + eff;
        exp_q.push_back({32'(fin), adr, to});
        for (int r = 1; r <= eff; r++) begin
            if (r == k) core_halt = 1'b1;
            if (r == rej_k) begin
                start = 1'b1;
                start_adr = PC_W'($urandom);
                rej_q.push_back(cyc + 1);
            end
            @(negedge clk);
            core_halt = 1'b0;
            start = 1'b0;
        end
        chk("finish_cycle", 64'(cyc), 64'(fin));
        chk("finish_rst", 64'(core_rst), 64'd1);
        chk("finish_en", 64'(core_en), 64'd0);
        if (fin_rej) begin
            start = 1'b1;
            start_adr = PC_W'($urandom);
            rej_q.push_back(cyc + 1);
        end
        @(negedge clk);
        start = 1'b0;
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_rst", 64'(core_rst), 64'd1);
        chk("idle_timeout", 64'(timeout), 64'(to));
        chk("idle_pc_init_kept", 64'(core_pc_init), 64'(adr));
    endtask

    task automatic reset_mid_run(input logic [PC_W-1:0] adr);
        start = 1'b1;
        start_adr = adr;
        @(negedge clk);
        start = 1'b0;
        repeat (B + 3) @(negedge clk);
        chk("pre_rst_run_en", 64'(core_en), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_core_rst", 64'(core_rst), 64'd1);
        chk("async_rst_core_en", 64'(core_en), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_pc_init", 64'(core_pc_init), 64'd0);
        chk("async_rst_end", 64'(end_pulse), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [PC_W-1:0] adr;
        int k;
        int rk;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_core_rst", 64'(core_rst), 64'd1);
        chk("reset_core_en", 64'(core_en), 64'd0);
        chk("reset_pc_load", 64'(core_pc_load), 64'd0);
        chk("reset_pc_init", 64'(core_pc_init), 64'd0);
        chk("reset_end", 64'(end_pulse), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_rej", 64'(start_rej), 64'd0);
        chk("reset_timeout", 64'(timeout), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        launch(13'h0100, 5, 0, 1'b0, 1'b0);   // basic launch
        launch(13'h0100, 6, 3, 1'b1, 1'b0);   // rejects during BOOT and RUN
        launch(13'h0555, 4, 0, 1'b0, 1'b1);   // start in FINISH rejected ...
        launch(13'h0ABC, 1, 0, 1'b0, 1'b0);   // ... start in first IDLE cycle accepted
        reset_mid_run(13'h1234);
        launch(13'h1FFF, 3, 0, 1'b0, 1'b0);   // clean launch after reset
`ifdef CORE_WATCHDOG_EN
        launch(13'h0042, 20, 0, 1'b0, 1'b0);  // watchdog forces finish
        launch(13'h0043, 8, 0, 1'b0, 1'b0);   // halt on the expiry cycle wins
        launch(13'h0044, 9, 4, 1'b0, 1'b0);
`else
        launch(13'h0042, 3000, 0, 1'b0, 1'b0); // long run, no early end
`endif
        for (int i = 0; i < 24; i++) begin
            adr = PC_W'($urandom);
            k   = $urandom_range(1, 12);
            rk  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, (k < 8) ? k : 8) : 0;
            launch(adr, k, rk, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("end_queue_drained", 64'(exp_q.size()), 64'd0);
        chk("rej_queue_drained", 64'(rej_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
